// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester command/response channels and the shared ALU hookup.
// The arbiter takes the slave side; the requesters and the ALU take the master side.
interface alu_arbiter_if;
    logic        req0_valid;
    logic        req0_ready;
    logic [3:0]  req0_op;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req1_valid;
    logic        req1_ready;
    logic [3:0]  req1_op;
    logic [31:0] req1_a;
    logic [31:0] req1_b;

    logic        rsp0_valid;
    logic        rsp0_ready;
    logic [31:0] rsp0_data;
    logic        rsp0_zero;
    logic        rsp1_valid;
    logic        rsp1_ready;
    logic [31:0] rsp1_data;
    logic        rsp1_zero;

    logic [3:0]  alu_op;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_sol;
    logic        alu_zero;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_data, rsp0_zero,
        output rsp1_valid, rsp1_data, rsp1_zero,
        input  rsp0_ready, rsp1_ready,
        output alu_op, alu_op1, alu_op2,
        input  alu_sol, alu_zero
    );

    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_data, rsp0_zero,
        input  rsp1_valid, rsp1_data, rsp1_zero,
        output rsp0_ready, rsp1_ready,
        input  alu_op, alu_op1, alu_op2,
        output alu_sol, alu_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one shared combinational ALU, with a single
// result register that is handed back to whichever requester was granted.
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    alu_arbiter_if.slave bus
);
    logic        res_valid_q, res_valid_d;
    logic        res_owner_q, res_owner_d;
    logic [31:0] res_data_q,  res_data_d;
    logic        res_zero_q,  res_zero_d;
    logic        ptr_q,       ptr_d;

    logic owner_ready;
    logic slot_free;
    logic grant0;
    logic grant1;

    // A held result frees the slot in the same cycle its owner consumes it.
    always_comb begin
        owner_ready = res_owner_q ? bus.rsp1_ready : bus.rsp0_ready;
        slot_free   = !res_valid_q || owner_ready;
        grant0      = reset_n && slot_free && bus.req0_valid &&
                      (!bus.req1_valid || !RR_EN || !ptr_q);
        grant1      = reset_n && slot_free && bus.req1_valid &&
                      (!bus.req0_valid || (RR_EN && ptr_q));
    end

    always_comb begin
        bus.req0_ready = grant0;
        bus.req1_ready = grant1;
        bus.alu_op     = 4'b0000;
        bus.alu_op1    = 32'd0;
        bus.alu_op2    = 32'd0;
        if (grant0) begin
            bus.alu_op  = bus.req0_op;
            bus.alu_op1 = bus.req0_a;
            bus.alu_op2 = bus.req0_b;
        end else if (grant1) begin
            bus.alu_op  = bus.req1_op;
            bus.alu_op1 = bus.req1_a;
            bus.alu_op2 = bus.req1_b;
        end
        bus.rsp0_valid = reset_n && res_valid_q && !res_owner_q;
        bus.rsp1_valid = reset_n && res_valid_q &&  res_owner_q;
        bus.rsp0_data  = res_data_q;
        bus.rsp1_data  = res_data_q;
        bus.rsp0_zero  = res_zero_q;
        bus.rsp1_zero  = res_zero_q;
    end

    always_comb begin
        res_valid_d = res_valid_q;
        res_owner_d = res_owner_q;
        res_data_d  = res_data_q;
        res_zero_d  = res_zero_q;
        ptr_d       = ptr_q;
        if (grant0 || grant1) begin
            res_valid_d = 1'b1;
            res_owner_d = grant1;
            res_data_d  = bus.alu_sol;
            res_zero_d  = bus.alu_zero;
            ptr_d       = grant0;
        end else if (res_valid_q && owner_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            res_valid_q <= 1'b0;
            res_owner_q <= 1'b0;
            res_data_q  <= 32'd0;
            res_zero_q  <= 1'b0;
            ptr_q       <= 1'b0;
        end else begin
            res_valid_q <= res_valid_d;
            res_owner_q <= res_owner_d;
            res_data_q  <= res_data_d;
            res_zero_q  <= res_zero_d;
            ptr_q       <= ptr_d;
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter with the same stimulus and
// checks each against a queue-based reference model.
module tb_alu_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        v0 = 0, v1 = 0, rr0 = 0, rr1 = 0;
    logic [3:0]  op0 = 0, op1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic        zero;
    } exp_t;

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'b0000: return a + b;
            4'b1000: return a - b;
            4'b0111: return a & b;
            4'b0110: return a | b;
            4'b0100: return a ^ b;
            4'b0001: return a << b[4:0];
            4'b0101: return a >> b[4:0];
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s (dut%0d) @%0t: got %0h expected %0h", name, inst, $time, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        localparam bit RR = (gi == 0);
        alu_arbiter_if ifc ();

        assign ifc.req0_valid = v0;
        assign ifc.req0_op    = op0;
        assign ifc.req0_a     = a0;
        assign ifc.req0_b     = b0;
        assign ifc.req1_valid = v1;
        assign ifc.req1_op    = op1;
        assign ifc.req1_a     = a1;
        assign ifc.req1_b     = b1;
        assign ifc.rsp0_ready = rr0;
        assign ifc.rsp1_ready = rr1;
        assign ifc.alu_sol    = alu_f(ifc.alu_op, ifc.alu_op1, ifc.alu_op2);
        assign ifc.alu_zero   = (ifc.alu_sol == 32'd0);

        alu_arbiter #(.RR_EN(RR)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (ifc.slave)
        );

        exp_t q[$];
        exp_t pend;
        bit   pend_v  = 0;
        bit   m_valid = 0;
        bit   m_owner = 0;
        bit   m_ptr   = 0;

        // Reference model: decides the grant from the rules, queues the result
        // that must surface one cycle later.
        always begin
            int   g;
            bit   free;
            @(posedge clk);
            if (pend_v) q.push_back(pend);
            pend_v = 0;
            #2;
            g = -1;
            if (!reset_n) begin
                m_valid = 0; m_owner = 0; m_ptr = 0;
                q.delete();
            end else begin
                free = !m_valid || (m_owner ? rr1 : rr0);
                if (free) begin
                    if (v0 && v1) g = RR ? int'(m_ptr) : 0;
                    else if (v0)  g = 0;
                    else if (v1)  g = 1;
                end
                if (g >= 0) begin
                    pend.owner = (g == 1);
                    pend.data  = (g == 1) ? alu_f(op1, a1, b1) : alu_f(op0, a0, b0);
                    pend.zero  = (pend.data == 32'd0);
                    pend_v     = 1;
                    m_valid = 1; m_owner = (g == 1); m_ptr = (g == 0);
                end else if (free) begin
                    m_valid = 0;
                end
            end
            chk("req0_ready", gi, ifc.req0_ready, g == 0);
            chk("req1_ready", gi, ifc.req1_ready, g == 1);
            chk("alu_op",  gi, ifc.alu_op,  g == 0 ? op0 : g == 1 ? op1 : 4'b0000);
            chk("alu_op1", gi, ifc.alu_op1, g == 0 ? a0  : g == 1 ? a1  : 32'd0);
            chk("alu_op2", gi, ifc.alu_op2, g == 0 ? b0  : g == 1 ? b1  : 32'd0);
        end

        // Monitor: compares whatever the DUT presents against the queue head.
        always @(negedge clk) begin
            exp_t e;
            if (!reset_n || q.size() == 0) begin
                chk("rsp0_valid_idle", gi, ifc.rsp0_valid, 0);
                chk("rsp1_valid_idle", gi, ifc.rsp1_valid, 0);
            end else begin
                e = q[0];
                chk("rsp0_valid", gi, ifc.rsp0_valid, !e.owner);
                chk("rsp1_valid", gi, ifc.rsp1_valid,  e.owner);
                chk("rsp_data", gi, e.owner ? ifc.rsp1_data : ifc.rsp0_data, e.data);
                chk("rsp_zero", gi, e.owner ? ifc.rsp1_zero : ifc.rsp0_zero, e.zero);
                if (e.owner ? rr1 : rr0) void'(q.pop_front());
            end
        end
    end

    task automatic step(input bit sv0, input bit sv1, input bit srr0, input bit srr1,
                        input bit srst_n, input bit rnd_cmd);
        @(posedge clk);
        #1;
        v0 = sv0; v1 = sv1; rr0 = srr0; rr1 = srr1; reset_n = srst_n;
        if (rnd_cmd) begin
            op0 = 4'($urandom_range(0, 15));
            op1 = 4'($urandom_range(0, 15));
            a0  = $urandom;
            a1  = $urandom;
            b0  = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
            b1  = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
        end
    endtask

    initial begin
        repeat (3) step(0, 0, 0, 0, 0, 0);

        // single add on requester 0: 5 + 7
        op0 = 4'b0000; a0 = 32'd5; b0 = 32'd7;
        step(1, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);

        // continuous contention with consumers always ready
        repeat (8) step(1, 1, 1, 1, 1, 1);
        step(0, 0, 1, 1, 1, 0);

        // requester 1 computes 9 - 9 then its consumer stalls for 3 cycles
        op1 = 4'b1000; a1 = 32'd9; b1 = 32'd9;
        step(0, 1, 0, 0, 1, 0);
        repeat (3) step(1, 1, 0, 0, 1, 0);
        step(1, 1, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);

        // held result discarded by reset, then contention restarts at requester 0
        step(1, 0, 0, 0, 1, 1);
        step(1, 1, 0, 0, 1, 1);
        step(1, 1, 0, 0, 0, 1);
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 1, 1, 1, 1);

        repeat (10) step(0, 0, 0, 0, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        repeat (10) step(0, 0, 0, 0, 1, 0);

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 63) != 0, 1);
        end

        repeat (4) step(0, 0, 1, 1, 1, 0);
        @(posedge clk);
        #3;
        chk("queue_drained", 0, g_dut[0].q.size(), 0);
        chk("queue_drained", 1, g_dut[1].q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter RR_EN, default 1, selecting arbitration: 1 = round-robin, 0 = fixed priority to requester 0.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports reqN_valid  input  1  requester N (N=0,1) holds a valid ALU command.
REQ-005 SHALL have ports reqN_ready  output  1  command from requester N accepted this cycle.
REQ-006 SHALL have ports reqN_op  input  4  requester N ALU operation code, passed through unmodified.
REQ-007 SHALL have ports reqN_a, reqN_b  input  32  requester N first and second operands.
REQ-008 SHALL have ports rspN_valid  output  1  result for requester N is held.
REQ-009 SHALL have ports rspN_ready  input  1  requester N consumes its result this cycle.
REQ-010 SHALL have ports rspN_data  output  32 and rspN_zero  output  1  registered result and zero flag.
REQ-011 SHALL have ports alu_op  output  4, alu_op1 and alu_op2  output  32  driving the shared combinational ALU.
REQ-012 SHALL have ports alu_sol  input  32 and alu_zero  input  1  returned by the shared ALU in the same cycle.

Function
REQ-013 SHALL hold one result register: res_valid, res_owner (0/1), res_data[31:0], res_zero.
REQ-014 SHALL define slot free as !res_valid OR (rsp<res_owner>_ready AND res_valid).
REQ-015 SHALL grant at most one requester per cycle, only when slot free; a grant requires reqN_valid.
REQ-016 With one valid requester, SHALL grant that requester.
REQ-017 With both valid, RR_EN=1: SHALL grant the requester selected by priority pointer ptr; RR_EN=0: SHALL grant requester 0.
REQ-018 On each grant, SHALL set ptr to the non-granted requester; ptr SHALL NOT change without a grant.
REQ-019 reqN_ready SHALL be 1 only in the cycle requester N is granted; it is combinational from valids, ptr and slot state.
REQ-020 During a grant cycle, SHALL drive alu_op/alu_op1/alu_op2 from the granted requester's op/a/b; otherwise SHALL drive 4'b0000, 0, 0.
REQ-021 On a grant, SHALL capture alu_sol and alu_zero into res_data and res_zero, set res_valid=1 and set res_owner to the granted requester at the same edge; latency command-accept to rspN_valid is exactly 1 cycle.
REQ-022 rspN_valid SHALL equal res_valid AND (res_owner==N); rspN_data/rspN_zero SHALL present res_data/res_zero to both ports (meaningful only when valid).
REQ-023 Drain without new grant SHALL clear res_valid at the next edge; drain and new grant in the same cycle SHALL overwrite the register (back-to-back, one result per cycle).
REQ-024 While res_valid=1 and owner's rsp_ready=0, SHALL hold res_data/res_zero/res_owner stable and assert no reqN_ready.
REQ-025 rspN_ready while rspN_valid=0 SHALL have no effect.
REQ-026 Requester SHALL observe results in acceptance order; no command SHALL be dropped or duplicated.

Reset
REQ-027 When reset_n=0 at a rising edge: res_valid=0, res_owner=0, res_data=0, res_zero=0, ptr=0.
REQ-028 While reset_n=0: req0_ready=req1_ready=0, rsp0_valid=rsp1_valid=0, ALU outputs at idle values; an in-flight result SHALL be discarded.
REQ-029 First cycle after reset release SHALL allow a grant (slot free, ptr=0).

Verification
REQ-030 Single request: req0 op=0000 a=5 b=7, rsp0_ready=1 -> req0_ready=1 that cycle; next cycle rsp0_valid=1, rsp0_data=12, rsp0_zero=0.
REQ-031 Contention RR_EN=1: both valid continuously, rsp ready=1 -> grants alternate 0,1,0,1; one rsp valid per cycle, owners alternate.
REQ-032 Contention RR_EN=0: both valid continuously -> req0 granted every cycle; req1_ready stays 0.
REQ-033 Backpressure: req1 op=1000 a=9 b=9 accepted, rsp1_ready=0 for 3 cycles -> rsp1_valid=1, data=0, zero=1 held stable; no reqN_ready; grant resumes in the cycle rsp1_ready=1.
REQ-034 Reset mid-operation: result held with rsp0_ready=0, reset_n=0 one edge -> rsp0_valid=0, ptr=0; after release both valid -> req0 granted first.
REQ-035 Idle: no valids for 10 cycles -> alu_op=0000, alu_op1=alu_op2=0, no ready, ptr unchanged.
